// File: rtl/rib_master_arb.sv
// ---------------------------------------------------------------------------
// rib_master_arb
//
// Round-robin arbiter that shares one RIB master port between MASTERS
// requesters (for example the core data port and a DMA or debug master).
// The address phase is forwarded combinationally from the selected
// requester. Responses come back strictly in order and are steered to
// their originator through an in-order FIFO of requester indices, one
// entry per outstanding transfer.
//
// Parameters
//   MASTERS  number of requesters (2..8)
//   DEPTH    maximum outstanding transfers, ID FIFO size (power of 2)
//   IDW      width of a stored requester index, clog2(MASTERS) (min 1)
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_ribs_*            requester-side address phase, slice k = requester k
//   o_ribs_gnt          per-requester grant (one-hot or zero)
//   o_ribs_rsp          per-requester response valid (one-hot or zero)
//   i_ribs_rdy          per-requester response ready
//   o_ribs_rdata        downstream read data replicated to every slice
//   o_ribm_*/i_ribm_*   downstream RIB master port
//   o_err               sticky flag: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module rib_master_arb #(
    parameter int MASTERS = 2,
    parameter int DEPTH   = 4,
    parameter int IDW     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [32*MASTERS-1:0]   i_ribs_addr,
    input  logic [MASTERS-1:0]      i_ribs_wrcs,
    input  logic [4*MASTERS-1:0]    i_ribs_mask,
    input  logic [32*MASTERS-1:0]   i_ribs_wdata,
    output logic [32*MASTERS-1:0]   o_ribs_rdata,
    input  logic [MASTERS-1:0]      i_ribs_req,
    output logic [MASTERS-1:0]      o_ribs_gnt,
    output logic [MASTERS-1:0]      o_ribs_rsp,
    input  logic [MASTERS-1:0]      i_ribs_rdy,
    output logic [31:0]             o_ribm_addr,
    output logic                    o_ribm_wrcs,
    output logic [3:0]              o_ribm_mask,
    output logic [31:0]             o_ribm_wdata,
    input  logic [31:0]             i_ribm_rdata,
    output logic                    o_ribm_req,
    input  logic                    i_ribm_gnt,
    input  logic                    i_ribm_rsp,
    output logic                    o_ribm_rdy,
    output logic                    o_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pointer increment with explicit wrap so any DEPTH works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin successor of a requester index.
    function automatic logic [IDW-1:0] id_inc(input logic [IDW-1:0] id);
        return (id == IDW'(MASTERS - 1)) ? '0 : id + 1'b1;
    endfunction

    // Control state
    logic [IDW-1:0] prio;
    logic           lock;
    logic [IDW-1:0] lock_id;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    // ID FIFO storage (data only, never reset)
    logic [IDW-1:0] id_fifo [DEPTH];

    // Unpacked views of the requester payload buses
    logic [31:0]    addr_arr  [MASTERS];
    logic [31:0]    wdata_arr [MASTERS];
    logic [3:0]     mask_arr  [MASTERS];

    logic [IDW-1:0] rr_sel;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           found;
    int             cand;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    for (genvar k = 0; k < MASTERS; k++) begin : g_slice
        assign addr_arr[k]              = i_ribs_addr[32*k +: 32];
        assign wdata_arr[k]             = i_ribs_wdata[32*k +: 32];
        assign mask_arr[k]              = i_ribs_mask[4*k +: 4];
        assign o_ribs_rdata[32*k +: 32] = i_ribm_rdata;
    end

    // Round-robin search: first active request at or above prio, wrapping.
    always_comb begin
        rr_sel = prio;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < MASTERS; i++) begin
            cand = int'(prio) + i;
            if (cand >= MASTERS) begin
                cand = cand - MASTERS;
            end
            if (!found && i_ribs_req[IDW'(cand)]) begin
                rr_sel = IDW'(cand);
                found  = 1'b1;
            end
        end
    end

    // A stalled request keeps its requester selected until accepted.
    assign sel   = lock ? lock_id : rr_sel;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Address phase: zero-latency forwarding of the selected slice.
    // Issue is suppressed while reset is asserted so every output is
    // quiet during reset, not only after it.
    assign o_ribm_req   = i_ribs_req[sel] & ~full & ~i_rst;
    assign o_ribm_addr  = addr_arr[sel];
    assign o_ribm_wrcs  = i_ribs_wrcs[sel];
    assign o_ribm_mask  = mask_arr[sel];
    assign o_ribm_wdata = wdata_arr[sel];

    assign push = o_ribm_req & i_ribm_gnt;

    // Response phase: route to the oldest outstanding requester. A stray
    // response with nothing outstanding is never acknowledged.
    assign head       = id_fifo[rd_ptr];
    assign o_ribm_rdy = ~empty & i_ribs_rdy[head];
    assign pop        = i_ribm_rsp & o_ribm_rdy;

    always_comb begin
        o_ribs_gnt       = '0;
        o_ribs_rsp       = '0;
        o_ribs_gnt[sel]  = push;
        o_ribs_rsp[head] = i_ribm_rsp & ~empty;
    end

    // Control state update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prio    <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            o_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                prio   <= id_inc(sel);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // push is already blocked when full, so push&pop never overflows
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (o_ribm_req && !i_ribm_gnt) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end else if (push) begin
                lock    <= 1'b0;
            end
            // Judged on the pre-push count: a same-cycle grant does not
            // legitimise a response for an empty FIFO.
            if (i_ribm_rsp && empty) begin
                o_err <= 1'b1;
            end
        end
    end

    // ID FIFO write
    always_ff @(posedge i_clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_rib_master_arb.sv
// ---------------------------------------------------------------------------
// tb_rib_master_arb
//
// Directed scenarios followed by randomized traffic for rib_master_arb
// (MASTERS=2, DEPTH=4). A queue-based reference model of outstanding
// transfers predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rib_master_arb;

    localparam int M = 2;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [32*M-1:0] ribs_addr;
    logic [M-1:0]    ribs_wrcs;
    logic [4*M-1:0]  ribs_mask;
    logic [32*M-1:0] ribs_wdata;
    logic [32*M-1:0] ribs_rdata;
    logic [M-1:0]    ribs_req;
    logic [M-1:0]    ribs_gnt;
    logic [M-1:0]    ribs_rsp;
    logic [M-1:0]    ribs_rdy;
    logic [31:0]     ribm_addr;
    logic            ribm_wrcs;
    logic [3:0]      ribm_mask;
    logic [31:0]     ribm_wdata;
    logic [31:0]     ribm_rdata;
    logic            ribm_req;
    logic            ribm_gnt;
    logic            ribm_rsp;
    logic            ribm_rdy;
    logic            err;

    rib_master_arb #(.MASTERS(M), .DEPTH(D), .IDW(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ribs_addr  (ribs_addr),
        .i_ribs_wrcs  (ribs_wrcs),
        .i_ribs_mask  (ribs_mask),
        .i_ribs_wdata (ribs_wdata),
        .o_ribs_rdata (ribs_rdata),
        .i_ribs_req   (ribs_req),
        .o_ribs_gnt   (ribs_gnt),
        .o_ribs_rsp   (ribs_rsp),
        .i_ribs_rdy   (ribs_rdy),
        .o_ribm_addr  (ribm_addr),
        .o_ribm_wrcs  (ribm_wrcs),
        .o_ribm_mask  (ribm_mask),
        .o_ribm_wdata (ribm_wdata),
        .i_ribm_rdata (ribm_rdata),
        .o_ribm_req   (ribm_req),
        .i_ribm_gnt   (ribm_gnt),
        .i_ribm_rsp   (ribm_rsp),
        .o_ribm_rdy   (ribm_rdy),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    // Reference model: queue of outstanding requester indices
    int       q[$];
    int       m_prio;
    bit       m_lock;
    int       m_lock_id;
    bit       m_err;
    bit [M-1:0] last_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check all outputs against the model for the current inputs, advance
    // the model, then move to 1 time unit after the next rising edge.
    task automatic cycle();
        int         sel;
        bit         ereq;
        bit         erdy;
        bit [M-1:0] egnt;
        bit [M-1:0] ersp;
        #1;
        if (rst) begin
            check_eq("rst_req", ribm_req, 0);
            check_eq("rst_gnt", ribs_gnt, 0);
            check_eq("rst_rsp", ribs_rsp, 0);
            check_eq("rst_rdy", ribm_rdy, 0);
            check_eq("rst_err", err, 0);
            q.delete();
            m_prio    = 0;
            m_lock    = 0;
            m_lock_id = 0;
            m_err     = 0;
            last_gnt  = '0;
        end else begin
            if (m_lock) begin
                sel = m_lock_id;
            end else begin
                sel = m_prio;
                for (int i = 0; i < M; i++) begin
                    int c;
                    c = (m_prio + i) % M;
                    if (ribs_req[c]) begin
                        sel = c;
                        break;
                    end
                end
            end
            ereq = ribs_req[sel] && (q.size() < D);
            egnt = '0;
            if (ereq && ribm_gnt) egnt[sel] = 1'b1;
            erdy = 1'b0;
            ersp = '0;
            if (q.size() > 0) begin
                erdy = ribs_rdy[q[0]];
                if (ribm_rsp) ersp[q[0]] = 1'b1;
            end
            check_eq("req", ribm_req, ereq);
            check_eq("gnt", ribs_gnt, egnt);
            check_eq("rsp", ribs_rsp, ersp);
            check_eq("rdy", ribm_rdy, erdy);
            check_eq("err", err, m_err);
            if (ereq) begin
                check_eq("addr",  ribm_addr,  ribs_addr[32*sel +: 32]);
                check_eq("wrcs",  ribm_wrcs,  ribs_wrcs[sel]);
                check_eq("mask",  ribm_mask,  ribs_mask[4*sel +: 4]);
                check_eq("wdata", ribm_wdata, ribs_wdata[32*sel +: 32]);
            end
            for (int k = 0; k < M; k++) begin
                check_eq("rdata", ribs_rdata[32*k +: 32], ribm_rdata);
            end
            if (ribm_rsp && q.size() == 0) m_err = 1'b1;
            if (ribm_rsp && erdy) void'(q.pop_front());
            if (ereq && ribm_gnt) begin
                q.push_back(sel);
                m_prio = (sel + 1) % M;
            end
            if (ereq && !ribm_gnt) begin
                m_lock    = 1'b1;
                m_lock_id = sel;
            end else if (ereq && ribm_gnt) begin
                m_lock    = 1'b0;
            end
            last_gnt = egnt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ribs_req   = '0;
        ribm_gnt   = 1'b0;
        ribm_rsp   = 1'b0;
        ribs_rdy   = '0;
    endtask

    task automatic rand_slice(input int k);
        ribs_addr[32*k +: 32]  = $urandom;
        ribs_wdata[32*k +: 32] = $urandom;
        ribs_mask[4*k +: 4]    = 4'($urandom);
        ribs_wrcs[k]           = 1'($urandom);
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < M; k++) rand_slice(k);
        ribm_rdata = 32'h0;
        idle();
        // Reset state, with requests active to show issue is held off
        rst      = 1'b1;
        ribs_req = 2'b11;
        #1;
        check_eq("reset_req", ribm_req, 0);
        check_eq("reset_gnt", ribs_gnt, 0);
        cycle();
        rst = 1'b0;
        idle();

        // Single read from m0
        ribs_req = 2'b01;
        ribs_addr[31:0] = 32'hf100_0004;
        ribm_gnt = 1'b1;
        #1;
        check_eq("single_gnt", ribs_gnt, 2'b01);
        check_eq("single_addr", ribm_addr, 32'hf100_0004);
        cycle();
        idle();
        cycle();
        ribm_rsp   = 1'b1;
        ribm_rdata = 32'h5A;
        ribs_rdy   = 2'b01;
        #1;
        check_eq("single_rsp", ribs_rsp, 2'b01);
        check_eq("single_rdata", ribs_rdata[31:0], 32'h5A);
        check_eq("single_rdy", ribm_rdy, 1);
        cycle();
        ribm_rsp = 1'b0;
        ribs_rdy = 2'b11;
        #1;
        check_eq("single_empty_rdy", ribm_rdy, 0);
        cycle();

        // Contention: grants alternate starting with m0, then drain in order
        reset_pulse();
        ribs_req = 2'b11;
        ribm_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("contend_gnt", ribs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
        end
        idle();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("contend_rsp", ribs_rsp, (i % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
        end
        idle();

        // Full: fifth request is held off; a pop does not admit a push that cycle
        reset_pulse();
        ribs_req = 2'b01;
        ribm_gnt = 1'b1;
        repeat (4) cycle();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b01;
        #1;
        check_eq("full_req", ribm_req, 0);
        check_eq("full_gnt", ribs_gnt, 0);
        cycle();
        ribm_rsp = 1'b0;
        #1;
        check_eq("resume_req", ribm_req, 1);
        check_eq("resume_gnt", ribs_gnt, 2'b01);
        cycle();
        idle();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b11;
        repeat (4) cycle();
        idle();

        // Lock: m1 stalled by the slave keeps the port while m0 joins
        reset_pulse();
        ribs_addr[63:32] = 32'hA1A1_0000;
        ribs_addr[31:0]  = 32'hB0B0_0000;
        ribs_req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ribs_req = 2'b11;
            #1;
            check_eq("lock_addr", ribm_addr, 32'hA1A1_0000);
            cycle();
        end
        ribm_gnt = 1'b1;
        #1;
        check_eq("lock_gnt_m1", ribs_gnt, 2'b10);
        cycle();
        ribs_req = 2'b01;
        #1;
        check_eq("lock_gnt_m0", ribs_gnt, 2'b01);
        cycle();
        idle();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b11;
        repeat (2) cycle();
        idle();

        // Ordering: m0,m1,m0 outstanding; m1 stalls its response for 2 cycles
        reset_pulse();
        ribs_req = 2'b11;
        ribm_gnt = 1'b1;
        repeat (2) cycle();
        ribs_req = 2'b01;
        cycle();
        idle();
        ribm_rsp   = 1'b1;
        ribs_rdy   = 2'b11;
        ribm_rdata = 32'hD0;
        #1;
        check_eq("order_d0", ribs_rsp, 2'b01);
        cycle();
        ribm_rdata = 32'hD1;
        ribs_rdy   = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("order_stall_rdy", ribm_rdy, 0);
            check_eq("order_stall_rsp", ribs_rsp, 2'b10);
            cycle();
        end
        ribs_rdy = 2'b11;
        #1;
        check_eq("order_d1", ribs_rsp, 2'b10);
        cycle();
        ribm_rdata = 32'hD2;
        #1;
        check_eq("order_d2", ribs_rsp, 2'b01);
        cycle();
        idle();

        // Stray response with empty FIFO
        reset_pulse();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b11;
        #1;
        check_eq("stray_rdy", ribm_rdy, 0);
        cycle();
        ribm_rsp = 1'b0;
        #1;
        check_eq("stray_err", err, 1);
        cycle();

        // Asynchronous reset in the middle of a transfer
        ribs_req = 2'b01;
        ribm_gnt = 1'b1;
        cycle();
        ribm_rsp = 1'b1;
        ribs_rdy = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_req", ribm_req, 0);
        check_eq("async_gnt", ribs_gnt, 0);
        check_eq("async_rsp", ribs_rsp, 0);
        check_eq("async_rdy", ribm_rdy, 0);
        check_eq("async_err", err, 0);
        cycle();
        rst = 1'b0;
        idle();

        // Randomized traffic against the model
        reset_pulse();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < M; k++) begin
                if (!(ribs_req[k] && !last_gnt[k])) begin
                    ribs_req[k] = ($urandom_range(0, 2) == 0);
                    if (ribs_req[k]) rand_slice(k);
                end
            end
            ribm_gnt   = 1'($urandom_range(0, 1));
            ribm_rsp   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            ribs_rdy   = M'($urandom);
            ribm_rdata = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
